// File: rtl/ro_block_mux_n.sv
// ro_block_mux_n
// N-channel readout scheduler. An internal binary count B advances on every
// enabled clock; the bit t that toggles in the matching gray code selects the
// channel sampled in that slot (t < N_CH reads channel t, otherwise idle).
// Channel k is therefore read once every 2^(k+1) enabled cycles.
//
// Optional feature macro: RO_CHTAG_EN (adds the out_ch port and register).
//
// Ports
//   clk_ext     in   1      rising-edge clock for all state
//   reset       in   1      asynchronous active-high reset
//   en          in   1      count/readout enable
//   in          in   N_CH   comparator outputs, in[k] is channel k
//   gray_out    out  CNT_W  registered gray count B ^ (B >> 1)
//   out_data    out  1      registered serial data bit
//   out_valid   out  1      out_data carries a channel sample this cycle
//   out_ch      out  CH_W   channel index of out_data (RO_CHTAG_EN only)
//   frame_start out  1      one-cycle pulse on the count wrap edge
module ro_block_mux_n #(
   parameter int CNT_W = 17,
   parameter int N_CH  = 8,
   parameter int CH_W  = 3
) (
   input  logic              clk_ext,
   input  logic              reset,
   input  logic              en,
   input  logic [N_CH-1:0]   in,
   output logic [CNT_W-1:0]  gray_out,
   output logic              out_data,
   output logic              out_valid,
`ifdef RO_CHTAG_EN
   output logic [CH_W-1:0]   out_ch,
`endif
   output logic              frame_start
);

   // Low N_CH bits set: positions of the slot one-hot that map to a channel.
   localparam logic [CNT_W-1:0] CH_MASK = {CNT_W{1'b1}} >> (CNT_W - N_CH);
   localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] MSB_HOT = {1'b1, {(CNT_W-1){1'b0}}};

   logic [CNT_W-1:0] bin_r;
   logic [CNT_W-1:0] bin_nxt_s;
   logic [CNT_W-1:0] slot_s;
   logic [CNT_W-1:0] in_ext_s;
   logic             wrap_s;
   logic             slot_valid_s;
   logic             slot_data_s;
`ifdef RO_CHTAG_EN
   logic [CH_W-1:0]  slot_ch_s;
`endif

   // Next count and the one-hot position of its lowest set bit (the gray
   // bit that toggles); a wrap to zero toggles the gray MSB.
   always_comb begin
      bin_nxt_s    = bin_r + ONE;
      wrap_s       = (bin_nxt_s == '0);
      slot_s       = wrap_s ? MSB_HOT : (bin_nxt_s & (~bin_nxt_s + ONE));
      in_ext_s     = CNT_W'(in);
      slot_valid_s = |(slot_s & CH_MASK);
      slot_data_s  = |(slot_s & in_ext_s);
   end

`ifdef RO_CHTAG_EN
   // Encode the slot one-hot into a channel index (only channel bits count).
   always_comb begin
      slot_ch_s = '0;
      for (int k = 0; k < CNT_W; k++) begin
         slot_ch_s = slot_ch_s | ((slot_s[k] & CH_MASK[k]) ? CH_W'(k) : '0);
      end
   end
`endif

   // Counter, gray register and readout registers; all outputs are flops.
   always_ff @(posedge clk_ext or posedge reset) begin
      if (reset) begin
         bin_r       <= '0;
         gray_out    <= '0;
         out_data    <= 1'b0;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
`ifdef RO_CHTAG_EN
         out_ch      <= '0;
`endif
      end else if (en) begin
         bin_r       <= bin_nxt_s;
         gray_out    <= bin_nxt_s ^ (bin_nxt_s >> 1);
         out_data    <= slot_valid_s & slot_data_s;
         out_valid   <= slot_valid_s;
         frame_start <= wrap_s;
`ifdef RO_CHTAG_EN
         // Tag holds through idle slots.
         if (slot_valid_s) begin
            out_ch <= slot_ch_s;
         end else begin
            out_ch <= out_ch;
         end
`endif
      end else begin
         bin_r       <= bin_r;
         gray_out    <= gray_out;
         out_data    <= 1'b0;
         out_valid   <= 1'b0;
         frame_start <= 1'b0;
`ifdef RO_CHTAG_EN
         out_ch      <= out_ch;
`endif
      end
   end

endmodule

// File: tb/tb_ro_block_mux_n.sv
// tb_ro_block_mux_n
// Directed bench for ro_block_mux_n with CNT_W=4. Instance u3 uses N_CH=3,
// instance u4 uses N_CH=CNT_W=4 so the wrap edge is also a channel slot.
// Channel tags are checked when RO_CHTAG_EN is defined.
module tb_ro_block_mux_n;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, en4;
   logic [2:0] in3;
   logic [3:0] in4;
   logic [3:0] gray3, gray4;
   logic       data3, data4, valid3, valid4, fs3, fs4;
`ifdef RO_CHTAG_EN
   logic [1:0] ch3, ch4;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] gray_t  [0:15];
   logic       valid_t [0:15];
   logic       data_t  [0:15];
   logic [1:0] ch_t    [0:15];
   logic [3:0] prev_gray;

   always #5 clk = ~clk;

   ro_block_mux_n #(.CNT_W(4), .N_CH(3), .CH_W(2)) u3 (
      .clk_ext(clk), .reset(reset), .en(en), .in(in3),
      .gray_out(gray3), .out_data(data3), .out_valid(valid3),
`ifdef RO_CHTAG_EN
      .out_ch(ch3),
`endif
      .frame_start(fs3)
   );

   ro_block_mux_n #(.CNT_W(4), .N_CH(4), .CH_W(2)) u4 (
      .clk_ext(clk), .reset(reset), .en(en4), .in(in4),
      .gray_out(gray4), .out_data(data4), .out_valid(valid4),
`ifdef RO_CHTAG_EN
      .out_ch(ch4),
`endif
      .frame_start(fs4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk3(input string tag, input logic [3:0] g, input logic v,
                       input logic d, input logic f, input logic [1:0] c);
      chk({tag, "_gray"},  32'(gray3),  32'(g));
      chk({tag, "_valid"}, 32'(valid3), 32'(v));
      chk({tag, "_data"},  32'(data3),  32'(d));
      chk({tag, "_frame"}, 32'(fs3),    32'(f));
`ifdef RO_CHTAG_EN
      chk({tag, "_ch"},    32'(ch3),    32'(c));
`else
      if (c == 2'd3) $display("unexpected tag value in table");
`endif
   endtask

   initial begin
      gray_t  = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                  4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
      valid_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      data_t  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      ch_t    = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0,
                  2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};

      // Reset state
      reset = 1'b1; en = 1'b0; en4 = 1'b0; in3 = 3'b101; in4 = 4'b1000;
      #12;
      chk3("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      reset = 1'b0;

      // One full frame with in=101: schedule 0,1,0,2,0,1,0,idle,... and wrap
      en = 1'b1;
      prev_gray = 4'b0000;
      for (int i = 0; i < 16; i++) begin
         step();
         chk3($sformatf("frame_b%0d", i + 1), gray_t[i], valid_t[i], data_t[i],
              (i == 15) ? 1'b1 : 1'b0, ch_t[i]);
         chk($sformatf("hamming_b%0d", i + 1), 32'($countones(prev_gray ^ gray3)), 32'd1);
         prev_gray = gray3;
      end

      // Advance to B=5, then pause for 5 cycles
      for (int i = 0; i < 5; i++) step();
      chk3("at_b5", 4'b0111, 1'b1, 1'b1, 1'b0, 2'd0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk3($sformatf("hold_%0d", i), 4'b0111, 1'b0, 1'b0, 1'b0, 2'd0);
      end
      en = 1'b1; in3 = 3'b010;
      step();
      chk3("resume_b6", 4'b0101, 1'b1, 1'b1, 1'b0, 2'd1);

      // Advance to B=10, then asynchronous reset mid-frame
      for (int i = 0; i < 4; i++) step();
      chk3("at_b10", 4'b1111, 1'b1, 1'b1, 1'b0, 2'd1);
      reset = 1'b1;
      #2;
      chk3("mid_reset", 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0);
      @(negedge clk);
      reset = 1'b0; in3 = 3'b001;
      step();
      chk3("post_reset_b1", 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0);

      // Input changes relative to slots
      step();
      chk3("ch1_b2", 4'b0011, 1'b1, 1'b0, 1'b0, 2'd1);
      in3 = 3'b000;
      step();
      chk3("in0_change_b3", 4'b0010, 1'b1, 1'b0, 1'b0, 2'd0);
      step();
      chk3("ch2_b4", 4'b0110, 1'b1, 1'b0, 1'b0, 2'd2);
      in3 = 3'b010;
      step();
      chk3("in1_during_ch0_b5", 4'b0111, 1'b1, 1'b0, 1'b0, 2'd0);
      step();
      chk3("in1_seen_b6", 4'b0101, 1'b1, 1'b1, 1'b0, 2'd1);

      // N_CH == CNT_W: the wrap edge reads channel 3
      en = 1'b0; en4 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 8) begin
            chk("u4_b8_valid", 32'(valid4), 32'd1);
            chk("u4_b8_data", 32'(data4), 32'd1);
            chk("u4_b8_frame", 32'(fs4), 32'd0);
`ifdef RO_CHTAG_EN
            chk("u4_b8_ch", 32'(ch4), 32'd3);
`endif
         end else if (i == 15) begin
            chk("u4_b15_valid", 32'(valid4), 32'd1);
            chk("u4_b15_data", 32'(data4), 32'd0);
            chk("u4_b15_frame", 32'(fs4), 32'd0);
         end else if (i == 16) begin
            chk("u4_wrap_gray", 32'(gray4), 32'd0);
            chk("u4_wrap_valid", 32'(valid4), 32'd1);
            chk("u4_wrap_data", 32'(data4), 32'd1);
            chk("u4_wrap_frame", 32'(fs4), 32'd1);
`ifdef RO_CHTAG_EN
            chk("u4_wrap_ch", 32'(ch4), 32'd3);
`endif
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
